// File: rtl/ex_pkg.sv
// Execute-stage encodings and mult/div latencies shared by ex_stage, ex_mdu and the bench.
// MADD/MADDU/MSUB/MSUBU encodings always exist; ex_mdu only honours them when EX_MADD_EN is defined.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLLV = 4'd9,
        ALU_SRLV = 4'd10,
        ALU_SRAV = 4'd11,
        ALU_SLT  = 4'd12,
        ALU_SLTU = 4'd13,
        ALU_LUI  = 4'd14
    } alu_op_e;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    // Operation held by the MDU for the duration of its busy window.
    typedef enum logic [2:0] {
        K_MUL   = 3'd0,
        K_MULU  = 3'd1,
        K_DIV   = 3'd2,
        K_DIVU  = 3'd3,
        K_MADD  = 3'd4,
        K_MADDU = 3'd5,
        K_MSUB  = 3'd6,
        K_MSUBU = 3'd7
    } md_kind_e;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CNT_W       = $clog2(DIV_CYCLES + 1);

    function automatic logic kind_is_signed(input md_kind_e k);
        return (k == K_MUL) || (k == K_DIV) || (k == K_MADD) || (k == K_MSUB);
    endfunction

    function automatic logic kind_is_div(input md_kind_e k);
        return (k == K_DIV) || (k == K_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus: decoded operation and operands in, result/overflow/busy out.
interface ex_stage_if;

    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic [3:0]  md_op;
    logic        md_start;
    logic [31:0] ex_result;
    logic        ovf;
    logic        md_busy;

    modport master (
        output alu_op, src_a, src_b, shamt, md_op, md_start,
        input  ex_result, ovf, md_busy
    );

    modport slave (
        input  alu_op, src_a, src_b, shamt, md_op, md_start,
        output ex_result, ovf, md_busy
    );

endinterface

// File: rtl/ex_mdu.sv
// Multiply/divide unit: HI/LO, latched operands and latency counter.
// Defining EX_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate operations.
module ex_mdu
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_busy
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_kind_e         kind_q, kind_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             start_valid;
    md_kind_e         start_kind;
    logic             signed_op;
    logic [63:0]      ext_a, ext_b, prod;
    logic [31:0]      divisor, quot, rem;
`ifdef EX_MADD_EN
    logic [63:0]      acc_add, acc_sub;
`endif

    assign md_busy = (cnt_q != '0);
    assign hi      = hi_q;
    assign lo      = lo_q;

    always_comb begin
        start_valid = 1'b0;
        start_kind  = K_MUL;
        case (md_op)
            MD_MULT:  begin start_valid = 1'b1; start_kind = K_MUL;   end
            MD_MULTU: begin start_valid = 1'b1; start_kind = K_MULU;  end
            MD_DIV:   begin start_valid = 1'b1; start_kind = K_DIV;   end
            MD_DIVU:  begin start_valid = 1'b1; start_kind = K_DIVU;  end
`ifdef EX_MADD_EN
            MD_MADD:  begin start_valid = 1'b1; start_kind = K_MADD;  end
            MD_MADDU: begin start_valid = 1'b1; start_kind = K_MADDU; end
            MD_MSUB:  begin start_valid = 1'b1; start_kind = K_MSUB;  end
            MD_MSUBU: begin start_valid = 1'b1; start_kind = K_MSUBU; end
`endif
            default:  ;
        endcase
    end

    // Sign- or zero-extend to 64 bits so one 64x64 truncated product serves both signednesses.
    always_comb begin
        signed_op = kind_is_signed(kind_q);
        ext_a     = signed_op ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b     = signed_op ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod      = ext_a * ext_b;
        divisor   = (b_q == '0) ? 32'd1 : b_q;
        if (signed_op) begin
            quot = 32'($signed(a_q) / $signed(divisor));
            rem  = 32'($signed(a_q) % $signed(divisor));
        end else begin
            quot = a_q / divisor;
            rem  = a_q % divisor;
        end
    end

`ifdef EX_MADD_EN
    assign acc_add = {hi_q, lo_q} + prod;
    assign acc_sub = {hi_q, lo_q} - prod;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                case (kind_q)
                    K_MUL, K_MULU: {hi_d, lo_d} = prod;
                    K_DIV, K_DIVU: begin
                        // A zero divisor burns the full latency but leaves HI/LO alone.
                        if (b_q != '0) begin
                            lo_d = quot;
                            hi_d = rem;
                        end
                    end
`ifdef EX_MADD_EN
                    K_MADD, K_MADDU: {hi_d, lo_d} = acc_add;
                    K_MSUB, K_MSUBU: {hi_d, lo_d} = acc_sub;
`endif
                    default: ;
                endcase
            end
        end else if (md_start && start_valid) begin
            a_d    = src_a;
            b_d    = src_b;
            kind_d = start_kind;
            cnt_d  = kind_is_div(start_kind) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_op == MD_MTHI) begin
            hi_d = src_a;
        end else if (md_op == MD_MTLO) begin
            lo_d = src_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            kind_q <= K_MUL;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, overflow detect and HI/LO result mux around ex_mdu.
// EX_MADD_EN (see ex_mdu) enables multiply-accumulate operations.
module ex_stage
    import ex_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);

    logic [31:0] hi, lo;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic [31:0] sum, diff;
    logic        md_busy;

    ex_mdu u_mdu (
        .clk      (clk),
        .reset    (reset),
        .md_op    (bus.md_op),
        .md_start (bus.md_start),
        .src_a    (bus.src_a),
        .src_b    (bus.src_b),
        .hi       (hi),
        .lo       (lo),
        .md_busy  (md_busy)
    );

    assign sum  = bus.src_a + bus.src_b;
    assign diff = bus.src_a - bus.src_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.src_a[31] == bus.src_b[31]) && (sum[31] != bus.src_a[31]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.src_a[31] != bus.src_b[31]) && (diff[31] != bus.src_a[31]);
            end
            ALU_AND:  alu_res = bus.src_a & bus.src_b;
            ALU_OR:   alu_res = bus.src_a | bus.src_b;
            ALU_XOR:  alu_res = bus.src_a ^ bus.src_b;
            ALU_NOR:  alu_res = ~(bus.src_a | bus.src_b);
            ALU_SLL:  alu_res = bus.src_b << bus.shamt;
            ALU_SRL:  alu_res = bus.src_b >> bus.shamt;
            ALU_SRA:  alu_res = 32'($signed(bus.src_b) >>> bus.shamt);
            ALU_SLLV: alu_res = bus.src_b << bus.src_a[4:0];
            ALU_SRLV: alu_res = bus.src_b >> bus.src_a[4:0];
            ALU_SRAV: alu_res = 32'($signed(bus.src_b) >>> bus.src_a[4:0]);
            ALU_SLT:  alu_res = {31'b0, $signed(bus.src_a) < $signed(bus.src_b)};
            ALU_SLTU: alu_res = {31'b0, bus.src_a < bus.src_b};
            ALU_LUI:  alu_res = {bus.src_b[15:0], 16'b0};
            default:  ;
        endcase
    end

    always_comb begin
        case (bus.md_op)
            MD_MFHI: bus.ex_result = hi;
            MD_MFLO: bus.ex_result = lo;
            default: bus.ex_result = alu_res;
        endcase
    end

    assign bus.ovf     = alu_ovf;
    assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage; expected values queued at drive time, popped at sample time.
// Build with EX_MADD_EN defined to exercise multiply-accumulate instead of its no-op behaviour.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic reset;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        expect_val({tag, "_hi"}, exp_hi);
        expect_val({tag, "_lo"}, exp_lo);
        bus.md_op = MD_MFHI;
        #1;
        check(bus.ex_result);
        bus.md_op = MD_MFLO;
        #1;
        check(bus.ex_result);
        bus.md_op = MD_NONE;
    endtask

    task automatic alu_step(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh,
                            input logic [31:0] exp_r, input logic exp_o);
        expect_val({tag, "_res"}, exp_r);
        expect_val({tag, "_ovf"}, {31'b0, exp_o});
        bus.alu_op = op;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.shamt  = sh;
        bus.md_op  = MD_NONE;
        #2;
        check(bus.ex_result);
        check({31'b0, bus.ovf});
    endtask

    // Start an MDU op, confirm MFHI still shows the old HI, count busy cycles, read HI/LO.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pre_hi, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.md_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        expect_val({tag, "_prehi"}, pre_hi);
        bus.md_op = MD_MFHI;
        #1;
        check(bus.ex_result);
        bus.md_op = MD_NONE;
        n = 0;
        while (bus.md_busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        expect_val({tag, "_busy_cycles"}, 32'(exp_cycles));
        check(32'(n));
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        reset        = 1'b1;
        bus.alu_op   = ALU_ADD;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.shamt    = '0;
        bus.md_op    = MD_NONE;
        bus.md_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        expect_val("reset_busy", 32'd0);
        check({31'b0, bus.md_busy});
        read_hilo("reset", 32'h0, 32'h0);

        alu_step("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h1,          5'd0,  32'h80000000, 1'b1);
        alu_step("add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'h1,          5'd0,  32'h00000000, 1'b0);
        alu_step("sub_ovf",  ALU_SUB,  32'h80000000, 32'h1,          5'd0,  32'h7FFFFFFF, 1'b1);
        alu_step("sub_neg",  ALU_SUB,  32'h5,        32'h7,          5'd0,  32'hFFFFFFFE, 1'b0);
        alu_step("and",      ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00,   5'd0,  32'hF000F000, 1'b0);
        alu_step("and_noov", ALU_AND,  32'h7FFFFFFF, 32'h1,          5'd0,  32'h00000001, 1'b0);
        alu_step("or",       ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00,   5'd0,  32'hFFF0FFF0, 1'b0);
        alu_step("xor",      ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00,   5'd0,  32'h0FF00FF0, 1'b0);
        alu_step("nor",      ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00,   5'd0,  32'h000F000F, 1'b0);
        alu_step("sll",      ALU_SLL,  32'h0,        32'h1,          5'd31, 32'h80000000, 1'b0);
        alu_step("srl",      ALU_SRL,  32'h0,        32'h80000000,   5'd4,  32'h08000000, 1'b0);
        alu_step("sra",      ALU_SRA,  32'h0,        32'h80000000,   5'd4,  32'hF8000000, 1'b0);
        alu_step("sllv",     ALU_SLLV, 32'h4,        32'h3,          5'd0,  32'h00000030, 1'b0);
        alu_step("srlv",     ALU_SRLV, 32'h24,       32'hF0,         5'd0,  32'h0000000F, 1'b0);
        alu_step("srav",     ALU_SRAV, 32'h1,        32'h80000000,   5'd0,  32'hC0000000, 1'b0);
        alu_step("slt",      ALU_SLT,  32'hFFFFFFFF, 32'h1,          5'd0,  32'h00000001, 1'b0);
        alu_step("sltu",     ALU_SLTU, 32'h1,        32'hFFFFFFFF,   5'd0,  32'h00000001, 1'b0);
        alu_step("sltu_0",   ALU_SLTU, 32'hFFFFFFFF, 32'h1,          5'd0,  32'h00000000, 1'b0);
        alu_step("lui",      ALU_LUI,  32'h0,        32'h00001234,   5'd0,  32'h12340000, 1'b0);
        alu_step("undef",    4'hF,     32'hFFFFFFFF, 32'hFFFFFFFF,   5'd0,  32'h00000000, 1'b0);

        run_md("mult",  MD_MULT,  32'hFFFFFFFF, 32'h2, 32'h0,         5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF,  5,  32'h00000001, 32'hFFFFFFFE);
        run_md("div",   MD_DIV,   32'hFFFFFFF9, 32'h2, 32'h00000001,  10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu0", MD_DIVU,  32'h7,        32'h0, 32'hFFFFFFFF,  10, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // Busy window: a second start and an MTLO must both be ignored.
        bus.md_op    = MD_DIVU;
        bus.src_a    = 32'h9;
        bus.src_b    = 32'h0;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        bus.md_op    = MD_NONE;
        tick();
        tick();
        bus.md_op    = MD_MULT;
        bus.src_a    = 32'h3;
        bus.src_b    = 32'h3;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        bus.md_op    = MD_MTLO;
        bus.src_a    = 32'h1234;
        tick();
        expect_val("busy_mflo_pre", 32'hFFFFFFFD);
        bus.md_op = MD_MFLO;
        #1;
        check(bus.ex_result);
        bus.md_op = MD_NONE;
        n = 4;
        while (bus.md_busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        expect_val("busy_ignore_cycles", 32'd10);
        check(32'(n));
        read_hilo("busy_mtlo", 32'hFFFFFFFF, 32'hFFFFFFFD);

        bus.md_op = MD_MTLO;
        bus.src_a = 32'h1234;
        tick();
        expect_val("mtlo_idle", 32'h00001234);
        bus.md_op = MD_MFLO;
        #1;
        check(bus.ex_result);
        bus.md_op = MD_MTHI;
        bus.src_a = 32'hABCD;
        tick();
        read_hilo("mthi_idle", 32'h0000ABCD, 32'h00001234);

        // Reset four cycles into a divide aborts it and clears HI/LO.
        bus.md_op    = MD_DIV;
        bus.src_a    = 32'd100;
        bus.src_b    = 32'd7;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        bus.md_op    = MD_NONE;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_val("abort_busy", 32'd0);
        check({31'b0, bus.md_busy});
        read_hilo("abort", 32'h0, 32'h0);

        bus.md_op = MD_MTHI;
        bus.src_a = 32'h55;
        tick();
        reset     = 1'b1;
        bus.md_op = MD_MTHI;
        bus.src_a = 32'h77;
        tick();
        reset        = 1'b1;
        bus.md_op    = MD_MULT;
        bus.md_start = 1'b1;
        tick();
        reset        = 1'b0;
        bus.md_start = 1'b0;
        bus.md_op    = MD_NONE;
        expect_val("rst_prio_busy", 32'd0);
        check({31'b0, bus.md_busy});
        read_hilo("rst_prio", 32'h0, 32'h0);

        bus.md_op = MD_MTLO;
        bus.src_a = 32'd5;
        tick();
        bus.md_op = MD_NONE;

        // Undefined md_op with a start pulse never goes busy.
        bus.md_op    = 4'hF;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        bus.md_op    = MD_NONE;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.md_busy !== 1'b0) seen = 1'b1;
            tick();
        end
        expect_val("undef_busy_seen", 32'd0);
        check({31'b0, seen});
        read_hilo("undef", 32'h0, 32'h5);

`ifdef EX_MADD_EN
        run_md("madd",  MD_MADD,  32'd3,        32'd4, 32'h0, 5, 32'h0, 32'd17);
        run_md("msubu", MD_MSUBU, 32'd2,        32'd3, 32'h0, 5, 32'h0, 32'd11);
        run_md("msub",  MD_MSUB,  32'hFFFFFFFF, 32'd2, 32'h0, 5, 32'h0, 32'd13);
`else
        run_md("madd",  MD_MADD,  32'd3,        32'd4, 32'h0, 0, 32'h0, 32'd5);
        run_md("msubu", MD_MSUBU, 32'd2,        32'd3, 32'h0, 0, 32'h0, 32'd5);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
